// File: rtl/window_3x3_generator.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_generator
// Description : Builds 3x3 pixel neighbourhoods from a raster-order padded
//               image stream. Two line buffers supply the pixels from one and
//               two rows above the incoming pixel. A 3x3 shift-register window
//               is fed from the line buffers and the input. Row and column
//               counters gate the output, so windows that would wrap across a
//               row boundary, or that contain rows from before the current
//               frame, are never emitted.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : synchronous, active-high reset
//   i_valid   : i_data carries a pixel this cycle (no backpressure)
//   i_data    : padded-image pixel, raster order
//   o_valid   : o_window holds a complete window (registered, 1-cycle latency)
//   o_window  : slice k = 3*r + c at [k*DATA_WIDTH +: DATA_WIDTH];
//               r = 0 is the top row, c = 0 is the left column, slice 8 is
//               the newest pixel
//   o_last    : high with o_valid on the final window of a frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module window_3x3_generator #(
    parameter int DATA_WIDTH  = 32,
    parameter int IMAGE_WIDTH = 6
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_valid,
    input  wire logic [DATA_WIDTH-1:0]   i_data,
    output logic                         o_valid,
    output logic [9*DATA_WIDTH-1:0]      o_window,
    output logic                         o_last
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_CNT_W  = $clog2(IMAGE_WIDTH) + 1;
    // Address width for the line buffers. IMAGE_WIDTH >= 3 keeps this >= 2.
    localparam int C_ADDR_W = $clog2(IMAGE_WIDTH);

    localparam logic [C_CNT_W-1:0] C_LAST_IDX = C_CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [C_CNT_W-1:0] C_FIRST_WIN_IDX = C_CNT_W'(2);

    // ------------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------------
    logic [C_CNT_W-1:0] r_col;
    logic [C_CNT_W-1:0] r_row;

    // A pixel is only taken when reset is not asserted in the same cycle.
    logic w_accept;
    logic w_col_last;
    logic w_row_last;
    logic w_emit;
    logic w_frame_end;

    assign w_accept    = i_valid && !rst;
    assign w_col_last  = (r_col == C_LAST_IDX);
    assign w_row_last  = (r_row == C_LAST_IDX);

    // A window is complete once the bottom-right pixel is at row >= 2 and
    // col >= 2. Columns 0 and 1 still hold pixels from the previous row in
    // the left part of the window, so they are suppressed.
    assign w_emit      = w_accept && (r_row >= C_FIRST_WIN_IDX)
                                  && (r_col >= C_FIRST_WIN_IDX);
    assign w_frame_end = w_col_last && w_row_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                // Wrapping both counters together gives a seamless start on
                // the next frame with no dead cycle.
                if (w_row_last) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + C_CNT_W'(1);
                end
            end else begin
                r_col <= r_col + C_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Line buffers
    //
    // Both buffers are addressed by the current column. The entry at that
    // address in buffer A was written exactly one row ago, and the entry in
    // buffer B was copied out of A one row ago, i.e. it is two rows old.
    // Contents are not reset: the row gating on w_emit guarantees that stale
    // entries from a previous or abandoned frame never reach the output.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_line_a [IMAGE_WIDTH];
    logic [DATA_WIDTH-1:0] r_line_b [IMAGE_WIDTH];

    logic [C_ADDR_W-1:0]   w_addr;
    logic [DATA_WIDTH-1:0] w_a_out;
    logic [DATA_WIDTH-1:0] w_b_out;

    assign w_addr  = r_col[C_ADDR_W-1:0];
    assign w_a_out = r_line_a[w_addr];
    assign w_b_out = r_line_b[w_addr];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line_a[w_addr] <= i_data;
            r_line_b[w_addr] <= w_a_out;
        end
    end

    // ------------------------------------------------------------------------
    // 3x3 window register
    //
    // r_win[row][col]; row 0 is the oldest image row (top), col 2 is the
    // newest column (right). Every accepted beat shifts all rows left by one
    // and loads the new right column {B, A, input} from top to bottom.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_win [3][3];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_b_out;
            r_win[1][2] <= w_a_out;
            r_win[2][2] <= i_data;
        end
    end

    // ------------------------------------------------------------------------
    // Output flags
    //
    // Both flags drop on any cycle without an emitting beat, including idle
    // cycles, so o_valid is a single-cycle pulse per window.
    // ------------------------------------------------------------------------
    logic r_valid;
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_last  <= w_emit && w_frame_end;
        end
    end

    assign o_valid = r_valid;
    assign o_last  = r_last;

    // ------------------------------------------------------------------------
    // Window packing: slice k = 3*r + c
    // ------------------------------------------------------------------------
    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            assign o_window[(3*gr + gc)*DATA_WIDTH +: DATA_WIDTH] = r_win[gr][gc];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_3x3_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_3x3_generator
// Description : Self-checking bench for window_3x3_generator. A reference
//               model stores the current frame as a 2-D image and, for every
//               accepted pixel at row >= 2 and col >= 2, cuts the 3x3
//               neighbourhood ending at that pixel. A monitor collects every
//               emitted window; each test compares the two lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_3x3_generator;

    localparam int DW = 32;
    localparam int IW = 6;
    localparam int WW = 9 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic [WW-1:0] o_window;
    logic          o_last;

    window_3x3_generator #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .o_window (o_window),
        .o_last   (o_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WW-1:0] w;
        logic          last;
    } win_t;

    win_t    exp_q[$];
    win_t    got_q[$];
    int      checks   = 0;
    int      failures = 0;
    int      stray    = 0;
    logic    mon_acc;

    int            m_row = 0;
    int            m_col = 0;
    logic [DW-1:0] img [IW][IW];

    // ------------------------------------------------------------------------
    // Monitor: collect windows; note any o_valid that does not follow an
    // accepted beat, and any o_last without o_valid.
    // ------------------------------------------------------------------------
    always @(posedge clk) begin
        mon_acc = i_valid && !rst;
        #1;
        if (o_valid) begin
            got_q.push_back('{w: o_window, last: o_last});
            if (!mon_acc) stray++;
        end
        if (o_last && !o_valid) stray++;
    end

    // ------------------------------------------------------------------------
    // Reference model: image array indexed by position within the frame.
    // ------------------------------------------------------------------------
    task automatic model_beat(input logic [DW-1:0] d);
        win_t e;
        img[m_row][m_col] = d;
        if (m_row >= 2 && m_col >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.w[(3*r + c)*DW +: DW] = img[m_row-2+r][m_col-2+c];
            e.last = (m_row == IW-1) && (m_col == IW-1);
            exp_q.push_back(e);
        end
        m_col++;
        if (m_col == IW) begin
            m_col = 0;
            m_row = (m_row + 1) % IW;
        end
    endtask

    function automatic logic [WW-1:0] mk(input int v0, v1, v2, v3, v4,
                                         v5, v6, v7, v8);
        logic [WW-1:0] w;
        w = {DW'(v8), DW'(v7), DW'(v6), DW'(v5), DW'(v4),
             DW'(v3), DW'(v2), DW'(v1), DW'(v0)};
        return w;
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------------
    task automatic send_beat(input logic v, input logic [DW-1:0] d);
        @(negedge clk);
        rst     = 1'b0;
        i_valid = v;
        i_data  = d;
        if (v) model_beat(d);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base, input int max_gap, input bit rnd);
        for (int p = 0; p < IW*IW; p++) begin
            send_beat(1'b1, rnd ? DW'($urandom) : DW'(base + p));
            if (max_gap > 0)
                repeat ($urandom_range(0, max_gap)) send_beat(1'b0, DW'($urandom));
        end
    endtask

    task automatic flush();
        send_beat(1'b0, '0);
        send_beat(1'b0, '0);
    endtask

    task automatic clear();
        exp_q.delete();
        got_q.delete();
        stray = 0;
    endtask

    // Reset pulse with a coincident valid beat that must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b1;
        i_data  = DW'(999);
        m_row   = 0;
        m_col   = 0;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; i_valid = 1'b0; i_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b want=0", o_valid);
        end
        checks++;
        if (o_last !== 1'b0) begin
            failures++; $display("FAIL reset_last got=%b want=0", o_last);
        end
        checks++;
        if (o_window !== '0) begin
            failures++; $display("FAIL reset_window got=%h want=0", o_window);
        end
    endtask

    task automatic test_basic_frame();
        int nlast;
        clear();
        send_frame(1, 0, 1'b0);
        flush();
        checks++;
        if (got_q.size() != 16) begin
            failures++; $display("FAIL basic_count got=%0d want=16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_win[%0d] got=%h/%b want=%h/%b", i,
                         got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        if (got_q.size() == 16) begin
            checks++;
            if (got_q[0].w !== mk(1,2,3,7,8,9,13,14,15)) begin
                failures++; $display("FAIL basic_first got=%h", got_q[0].w);
            end
            checks++;
            if (got_q[15] !== '{w: mk(22,23,24,28,29,30,34,35,36), last: 1'b1}) begin
                failures++;
                $display("FAIL basic_last got=%h/%b", got_q[15].w, got_q[15].last);
            end
        end
        nlast = 0;
        foreach (got_q[i]) if (got_q[i].last) nlast++;
        checks++;
        if (nlast != 1) begin
            failures++; $display("FAIL basic_last_count got=%0d want=1", nlast);
        end
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL basic_stray got=%0d want=0", stray);
        end
    endtask

    // Cycle-by-cycle: o_valid must follow exactly the beats whose position is
    // at row >= 2 and col >= 2 (pixel p is at row (p-1)/IW, col (p-1)%IW).
    task automatic test_row_wrap();
        logic want;
        clear();
        for (int p = 1; p <= IW*IW; p++) begin
            send_beat(1'b1, DW'(p));
            want = ((p-1)/IW >= 2) && ((p-1)%IW >= 2);
            checks++;
            if (o_valid !== want) begin
                failures++;
                $display("FAIL wrap_valid_after_pixel%0d got=%b want=%b", p, o_valid, want);
            end
            if (p == 21) begin
                checks++;
                if (o_window !== mk(7,8,9,13,14,15,19,20,21)) begin
                    failures++; $display("FAIL wrap_window21 got=%h", o_window);
                end
            end
        end
        flush();
    endtask

    task automatic test_stall();
        clear();
        send_frame(1, 3, 1'b0);
        flush();
        checks++;
        if (got_q.size() != 16) begin
            failures++; $display("FAIL stall_count got=%0d want=16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_win[%0d] got=%h/%b want=%h/%b", i,
                         got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL stall_stray got=%0d want=0", stray);
        end
    endtask

    task automatic test_back_to_back();
        int nlast;
        clear();
        send_frame(1, 0, 1'b0);
        send_frame(101, 0, 1'b0);
        flush();
        checks++;
        if (got_q.size() != 32) begin
            failures++; $display("FAIL b2b_count got=%0d want=32", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_win[%0d] got=%h/%b want=%h/%b", i,
                         got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        if (got_q.size() > 16) begin
            checks++;
            if (got_q[16].w !== mk(101,102,103,107,108,109,113,114,115)) begin
                failures++; $display("FAIL b2b_frame2_first got=%h", got_q[16].w);
            end
        end
        nlast = 0;
        foreach (got_q[i]) if (got_q[i].last) nlast++;
        checks++;
        if (nlast != 2) begin
            failures++; $display("FAIL b2b_last_count got=%0d want=2", nlast);
        end
    endtask

    task automatic test_reset_mid();
        clear();
        for (int p = 1; p <= 20; p++) send_beat(1'b1, DW'(p));
        do_reset();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_valid got=%b want=0", o_valid);
        end
        checks++;
        if (o_window !== '0) begin
            failures++; $display("FAIL midrst_window got=%h want=0", o_window);
        end
        clear();
        send_frame(201, 0, 1'b0);
        flush();
        checks++;
        if (got_q.size() != 16) begin
            failures++; $display("FAIL midrst_count got=%0d want=16", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midrst_win[%0d] got=%h/%b want=%h/%b", i,
                         got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0].w !== mk(201,202,203,207,208,209,213,214,215)) begin
                failures++; $display("FAIL midrst_first got=%h", got_q[0].w);
            end
        end
    endtask

    // A 4x4 image 1..16 surrounded by a one-pixel zero border.
    task automatic test_padding();
        clear();
        for (int r = 0; r < IW; r++)
            for (int c = 0; c < IW; c++)
                send_beat(1'b1, (r >= 1 && r <= 4 && c >= 1 && c <= 4)
                                ? DW'((r-1)*4 + c) : '0);
        flush();
        checks++;
        if (got_q.size() != 16) begin
            failures++; $display("FAIL pad_count got=%0d want=16", got_q.size());
        end
        if (got_q.size() == 16) begin
            checks++;
            if (got_q[0].w !== mk(0,0,0,0,1,2,0,5,6)) begin
                failures++; $display("FAIL pad_first got=%h", got_q[0].w);
            end
            checks++;
            if (got_q[15] !== '{w: mk(11,12,0,15,16,0,0,0,0), last: 1'b1}) begin
                failures++;
                $display("FAIL pad_last got=%h/%b", got_q[15].w, got_q[15].last);
            end
        end
    endtask

    task automatic test_random_frames();
        clear();
        send_frame(0, 2, 1'b1);
        send_frame(0, 1, 1'b1);
        flush();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_win[%0d] got=%h/%b want=%h/%b", i,
                         got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
            end
        end
        checks++;
        if (stray != 0) begin
            failures++; $display("FAIL rand_stray got=%0d want=0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_row_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_padding();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/window_3x3_generator.md
Name: window_3x3_generator

Overview:
- Sits directly downstream of the zero-padding stage.
- Consumes the padded image as a raster-order pixel stream and emits every complete 3x3 neighbourhood as one wide word, ready for the 3x3 convolution MAC array.
- Implements two line buffers plus a 3x3 shift-register window, with row/column tracking so that windows wrapping across rows are suppressed.

Parameters:
- DATA_WIDTH, 32, bits per pixel.
- IMAGE_WIDTH, 6, width and height of the square padded input image (unpadded width + 2). Legal range is 3 or more.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  i_data carries a pixel this cycle.
- i_data  input  DATA_WIDTH  padded-image pixel, raster order (row 0 col 0 first).
- o_valid  output  1  o_window holds a complete window this cycle.
- o_window  output  9*DATA_WIDTH  window; slice k = 3*r + c at [k*DATA_WIDTH +: DATA_WIDTH]; r=0 top row, c=0 left column; slice 8 is the newest pixel.
- o_last  output  1  high with o_valid on the final window of a frame.

Behaviour:
- Interface timing and flow control:
  - One clock; reset is synchronous and active-high.
  - No backpressure: every i_valid beat is accepted.
  - Idle cycles (i_valid low) are allowed anywhere, including mid-row. No internal state advances on those cycles.
- Counters:
  - col and row count 0..IMAGE_WIDTH-1 and identify the position of the accepted pixel.
  - On each beat col increments. At IMAGE_WIDTH-1, col wraps to 0 and row increments.
  - When row and col are both IMAGE_WIDTH-1, both wrap to 0, ready for the next frame with no dead cycle.
- Line buffers:
  - Two buffers, each IMAGE_WIDTH deep, DATA_WIDTH wide; they advance only on accepted beats.
  - Buffer A supplies the pixel from the previous row, same column. Buffer B supplies the pixel from two rows up.
  - On each beat the incoming pixel is written to A, and A's outgoing pixel is written to B.
- Window register:
  - A 3x3 array; on each beat all three rows shift left by one column.
  - The new right column is {B_out, A_out, i_data}, top to bottom.
- Output generation:
  - o_valid is registered. It is asserted the cycle after an accepted beat at row>=2 and col>=2, and deasserted otherwise, including idle cycles. Latency is therefore 1 cycle.
  - Windows per frame: (IMAGE_WIDTH-2)^2, in raster order of the window's bottom-right pixel.
  - Beats at col 0 and col 1 never produce a window, so no window straddles two rows.
  - o_last is asserted with o_valid only for the beat at row=col=IMAGE_WIDTH-1. It is low otherwise.
  - o_window is updated on every accepted beat. Its value is only meaningful while o_valid is high.
- Reset:
  - When rst is high at a clock edge: o_valid=0, o_last=0, o_window=0, col=0, row=0.
  - Line-buffer contents need not be cleared; the counter gating guarantees that stale data is never emitted.
  - Reset mid-frame abandons the partial frame. The next accepted beat is treated as row 0 col 0.
  - i_valid coincident with rst is ignored.
- Arithmetic:
  - Pixels pass through unmodified, with no sign or width change.
  - Counter widths are $clog2(IMAGE_WIDTH)+1.

Test Plan:
- Basic frame:
  - Stimulus: IMAGE_WIDTH=6, i_data=1..36 contiguous.
  - Required response: 16 o_valid pulses. The first comes one cycle after pixel 15, with window {1,2,3,7,8,9,13,14,15} (slice 0..8). The last is {22,23,24,28,29,30,34,35,36} with o_last=1, and o_last is low on the other 15 windows.
- Row-wrap suppression:
  - Stimulus: same frame.
  - Required response: no o_valid after pixels 19 and 20 (col 0,1 of row 3). The window after pixel 21 is {7,8,9,13,14,15,19,20,21}.
- Stalled input:
  - Stimulus: same frame with i_valid low for 0–3 random cycles between beats.
  - Required response: the identical 16-window sequence. o_valid is never high on a cycle that does not follow an accepted beat.
- Back-to-back frames:
  - Stimulus: 1..36 immediately followed by 101..136.
  - Required response: 32 windows. The first window of frame 2 is {101,102,103,107,108,109,113,114,115}, and o_last is asserted exactly twice.
- Reset mid-frame:
  - Stimulus: 20 beats of 1..20, then rst high for 1 cycle, then a full frame 201..236.
  - Required response: o_valid=0 and o_window=0 the cycle after reset, then exactly 16 windows. The first is {201,202,203,207,208,209,213,214,215}.
- Integration with upstream padding stage:
  - Stimulus: a 4x4 image of values 1..16 fed through the padding block into this block.
  - Required response: 16 windows. The first is {0,0,0,0,1,2,0,5,6} and the last is {11,12,0,15,16,0,0,0,0}.
